// File: rtl/adc_pulse_generator.sv
// -----------------------------------------------------------------------------
// adc_pulse_generator
//
// Synthetic ADC sample source. Produces detector-like pulses on a programmable
// baseline: a linear rise made of 2^rise_shift equal steps up to the latched
// amplitude, then an exponential decay (tail -= tail >> decay_shift each
// sample). Optional pseudo-random noise comes from a 16-bit Fibonacci LFSR.
// One signed sample is produced every clock.
//
// Ports:
//   clk          sample clock
//   reset        asynchronous, active-high reset
//   trigger      pulse request, level-sampled on every clk edge
//   amplitude    unsigned pulse height (SIZE_ADC_DATA-1 bits)
//   rise_shift   rise lasts 2^rise_shift samples
//   decay_shift  decay factor, tail -= tail >> decay_shift per sample
//   baseline     signed DC offset, applied immediately
//   noise_en     add LFSR noise to the output, applied immediately
//   adc_data     registered signed sample
//   busy         high while a pulse is in progress
//   pulse_start  one-cycle strobe when a trigger is accepted
//   missed_cnt   saturating count of triggers ignored while busy
// -----------------------------------------------------------------------------
module adc_pulse_generator #(
  parameter int          SIZE_ADC_DATA = 12,
  parameter int          NOISE_BITS    = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            trigger,
  input  logic        [SIZE_ADC_DATA-2:0] amplitude,
  input  logic        [2:0]               rise_shift,
  input  logic        [3:0]               decay_shift,
  input  logic signed [SIZE_ADC_DATA-1:0] baseline,
  input  logic                            noise_en,
  output logic signed [SIZE_ADC_DATA-1:0] adc_data,
  output logic                            busy,
  output logic                            pulse_start,
  output logic        [7:0]               missed_cnt
);

  localparam int W  = SIZE_ADC_DATA;
  localparam int TW = SIZE_ADC_DATA - 1;  // tail / amplitude width
  localparam int SW = SIZE_ADC_DATA + 2;  // headroom for baseline + tail + noise

  localparam logic signed [SW-1:0] SAT_MAX      = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN      = SW'(-(2 ** (W - 1)));
  localparam logic signed [SW-1:0] NOISE_OFFSET = SW'(2 ** (NOISE_BITS - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [TW-1:0] tail_reg, tail_next;
  logic [TW-1:0] amp_reg, amp_next;
  logic [TW-1:0] inc_reg, inc_next;
  logic [2:0]    rs_reg, rs_next;
  logic [3:0]    ds_reg, ds_next;
  logic [6:0]    cnt_reg, cnt_next;
  logic [7:0]    missed_reg, missed_next;
  logic          pulse_start_reg, pulse_start_next;
  logic          busy_reg;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic signed [W-1:0] adc_reg, adc_next;

  // ---------------------------------------------------------------------------
  // LFSR: shift left, feedback from taps 15, 13, 12, 10 into bit 0.
  // ---------------------------------------------------------------------------
  logic lfsr_feedback;
  assign lfsr_feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_next[0]  = lfsr_feedback;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Rise bookkeeping. cnt counts rise edges already taken; the rise ends on the
  // edge where cnt+1 reaches 2^rs-1, so the last rise sample is amp exactly
  // (absorbing any truncation of amp >> rs). Widened to 8 bits so rs=7 fits.
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_inc;
  logic [7:0] rise_last;
  assign cnt_inc   = {1'b0, cnt_reg} + 8'd1;
  assign rise_last = (8'd1 << rs_reg) - 8'd1;

  logic [TW-1:0] decay_step;
  assign decay_step = tail_reg >> ds_reg;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    tail_next        = tail_reg;
    amp_next         = amp_reg;
    inc_next         = inc_reg;
    rs_next          = rs_reg;
    ds_next          = ds_reg;
    cnt_next         = cnt_reg;
    pulse_start_next = 1'b0;
    missed_next      = missed_reg;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          amp_next         = amplitude;
          rs_next          = rise_shift;
          ds_next          = decay_shift;
          inc_next         = amplitude >> rise_shift;
          cnt_next         = '0;
          pulse_start_next = 1'b1;
          if (rise_shift == 3'd0) begin
            tail_next  = amplitude;
            state_next = DECAY;
          end else begin
            tail_next  = amplitude >> rise_shift;
            state_next = RISE;
          end
        end
      end

      RISE: begin
        cnt_next = cnt_inc[6:0];
        if (cnt_inc == rise_last) begin
          tail_next  = amp_reg;
          state_next = DECAY;
        end else begin
          tail_next = tail_reg + inc_reg;
        end
      end

      DECAY: begin
        // A zero step would never terminate, so it ends the pulse instead.
        if ((ds_reg == 4'd0) || (decay_step == '0)) begin
          tail_next  = '0;
          state_next = IDLE;
        end else begin
          tail_next = tail_reg - decay_step;
        end
      end

      default: begin
        tail_next  = '0;
        state_next = IDLE;
      end
    endcase

    // Any trigger seen while not IDLE is dropped, including the DECAY exit edge.
    if (trigger && (state_reg != IDLE) && (missed_reg != 8'hFF)) begin
      missed_next = missed_reg + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output sample: sat(baseline + tail + noise) using this cycle's tail/LFSR,
  // so the pulse appears on adc_data one cycle after the tail register.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] noise_val;
  logic signed [SW-1:0] sum_val;
  logic signed [SW-1:0] sum_sat;

  always_comb begin
    noise_val = '0;
    if (noise_en) begin
      noise_val = $signed({{(SW-NOISE_BITS){1'b0}}, lfsr_reg[NOISE_BITS-1:0]}) - NOISE_OFFSET;
    end

    sum_val = $signed({{(SW-W){baseline[W-1]}}, baseline})
            + $signed({{(SW-TW){1'b0}}, tail_reg})
            + noise_val;

    if (sum_val > SAT_MAX) begin
      sum_sat = SAT_MAX;
    end else if (sum_val < SAT_MIN) begin
      sum_sat = SAT_MIN;
    end else begin
      sum_sat = sum_val;
    end

    adc_next = sum_sat[W-1:0];
  end

  // ---------------------------------------------------------------------------
  // State register. busy is registered alongside the state so it matches the
  // state that the current tail sample belongs to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      tail_reg        <= '0;
      amp_reg         <= '0;
      inc_reg         <= '0;
      rs_reg          <= '0;
      ds_reg          <= '0;
      cnt_reg         <= '0;
      pulse_start_reg <= 1'b0;
      missed_reg      <= '0;
      busy_reg        <= 1'b0;
      lfsr_reg        <= LFSR_SEED;
      adc_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      tail_reg        <= tail_next;
      amp_reg         <= amp_next;
      inc_reg         <= inc_next;
      rs_reg          <= rs_next;
      ds_reg          <= ds_next;
      cnt_reg         <= cnt_next;
      pulse_start_reg <= pulse_start_next;
      missed_reg      <= missed_next;
      busy_reg        <= (state_next != IDLE);
      lfsr_reg        <= lfsr_next;
      adc_reg         <= adc_next;
    end
  end

  assign adc_data    = adc_reg;
  assign busy        = busy_reg;
  assign pulse_start = pulse_start_reg;
  assign missed_cnt  = missed_reg;

endmodule
